// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - 1-D convolution sequencer and MAC engine (z = x * y) for the conv AIP wrapper.
// Optional macro CONV_SAT_EN: z_data saturates to the signed DATA_WIDTH range instead of wrapping.
module conv_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_X     = 5,
  parameter int ADDR_Z     = 6
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  start,
  input  logic [4:0]            conf_len_x,
  input  logic [4:0]            conf_len_y,
  input  logic                  conf_shape,
  output logic [ADDR_X-1:0]     x_addr,
  output logic [ADDR_X-1:0]     y_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] x_data,
  input  logic [DATA_WIDTH-1:0] y_data,
  output logic [ADDR_Z-1:0]     z_addr,
  output logic [DATA_WIDTH-1:0] z_data,
  output logic                  z_we,
  output logic                  busy,
  output logic                  done
);
  localparam int AW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_DRAIN, S_WRITE, S_FIN
  } state_t;

  state_t                r_state, w_next;
  logic [4:0]            r_lx, r_ly;
  logic                  r_full;
  logic [5:0]            r_n, r_n0, r_nend;
  logic [4:0]            r_k;
  logic                  r_rd_d, r_first_d;
  logic signed [AW-1:0]  r_acc;
  logic [5:0]            w_off, w_n0, w_nend;
  logic [4:0]            w_kmin, w_kmax;
  logic signed [AW-1:0]  w_x_ext, w_y_ext, w_prod;
  logic [DATA_WIDTH-1:0] w_z;

  // Lowest k contributing to output n: max(0, n-LY+1).
  function automatic logic [4:0] f_kmin(input logic [5:0] n, input logic [4:0] ly);
    logic [5:0] np1;
    np1 = n + 6'd1;
    f_kmin = (np1 > {1'b0, ly}) ? 5'(np1 - {1'b0, ly}) : 5'd0;
  endfunction

  assign w_off  = ({1'b0, r_ly} - 6'd1) >> 1;
  assign w_n0   = r_full ? 6'd0 : w_off;
  assign w_nend = r_full ? ({1'b0, r_lx} + {1'b0, r_ly} - 6'd2) : (w_off + {1'b0, r_lx} - 6'd1);
  assign w_kmin = f_kmin(r_n, r_ly);
  assign w_kmax = ({1'b0, r_lx} > r_n) ? 5'(r_n) : (r_lx - 5'd1);

  assign w_x_ext = {{DATA_WIDTH{x_data[DATA_WIDTH-1]}}, x_data};
  assign w_y_ext = {{DATA_WIDTH{y_data[DATA_WIDTH-1]}}, y_data};
  assign w_prod  = w_x_ext * w_y_ext;

`ifdef CONV_SAT_EN
  always_comb begin
    if (&r_acc[AW-1:DATA_WIDTH-1] || ~|r_acc[AW-1:DATA_WIDTH-1])
      w_z = r_acc[DATA_WIDTH-1:0];
    else if (r_acc[AW-1])
      w_z = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      w_z = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  assign w_z = r_acc[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    mem_rd = 1'b0;
    z_we   = 1'b0;
    x_addr = '0;
    y_addr = '0;
    z_addr = '0;
    z_data = '0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SETUP;
      S_SETUP: begin
        busy   = 1'b1;
        w_next = (r_lx == 5'd0 || r_ly == 5'd0) ? S_FIN : S_FETCH;
      end
      S_FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        x_addr = ADDR_X'(r_k);
        y_addr = ADDR_X'(r_n - {1'b0, r_k});
        if (r_k == w_kmax) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        z_we   = 1'b1;
        z_addr = ADDR_Z'(r_n - r_n0);
        z_data = w_z;
        w_next = (r_n >= r_nend) ? S_FIN : S_FETCH;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Read data lags the address by one cycle, so accumulation follows a delayed copy of mem_rd.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_lx      <= '0;
      r_ly      <= '0;
      r_full    <= 1'b0;
      r_n       <= '0;
      r_n0      <= '0;
      r_nend    <= '0;
      r_k       <= '0;
      r_rd_d    <= 1'b0;
      r_first_d <= 1'b0;
      r_acc     <= '0;
    end else begin
      r_rd_d    <= mem_rd;
      r_first_d <= mem_rd && (r_k == w_kmin);
      if (r_rd_d) r_acc <= r_first_d ? w_prod : (r_acc + w_prod);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_lx   <= conf_len_x;
            r_ly   <= conf_len_y;
            r_full <= conf_shape;
          end
        end
        S_SETUP: begin
          r_n    <= w_n0;
          r_n0   <= w_n0;
          r_nend <= w_nend;
          r_k    <= f_kmin(w_n0, r_ly);
        end
        S_FETCH: r_k <= r_k + 5'd1;
        S_WRITE: begin
          r_n <= r_n + 6'd1;
          r_k <= f_kmin(r_n + 6'd1, r_ly);
        end
        default: ;
      endcase
    end
  end

endmodule
